wb_arbiter: RTL

Two-master arbiter for the classic pipelined Wishbone B4 bus. It shares one slave port between two masters, e.g. J1 data port and a DMA engine. Ownership is granted per bus cycle (CYC) and held until the owner drops CYC. It tracks outstanding strobes so ACKs always route back to the master that issued them. Sits between the masters' `if_wb` ports and the slave-side interconnect; the bus protocol checker monitors the slave side.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_arb_sel.sv | 19 +
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef logic owner_t;

    // Width of the outstanding-strobe counter: must hold 0..max_out
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_arb_sel.sv
// wb_arb_sel: combinational two-request selector; the pointer breaks ties.
module wb_arb_sel
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     ptr,
    output owner_t     winner
);

    // A lone request wins outright; a tie goes to the master named by ptr
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11)
            winner = ptr;
        else if (req == 2'b10)
            winner = 1'b1;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master arbiter for classic pipelined Wishbone B4.
// Ownership is granted per CYC and held until the owner drops CYC; an
// outstanding-strobe counter throttles the owner at MAX_OUT in flight.
// Build macro WB_ARB_ROUND_ROBIN_EN: ties in IDLE go to the master not
// granted last. Without it master 0 always wins ties.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_m,
    output logic [DW-1:0] m0_dat_s,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_m,
    output logic [DW-1:0] m1_dat_s,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_m,
    input  logic [DW-1:0] s_dat_s,
    input  logic          s_ack,
    input  logic          s_stall,
    output logic [1:0]    gnt
);

    localparam int            CW      = cnt_width(MAX_OUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    state_t        state, state_nxt;
    owner_t        own, own_nxt;
    owner_t        rr_ptr, winner;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          any_req, own_cyc, own_stb, own_we;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic          full, accept, ack_cnt;

    assign any_req = m0_cyc | m1_cyc;
    assign own_cyc = own ? m1_cyc   : m0_cyc;
    assign own_stb = own ? m1_stb   : m0_stb;
    assign own_we  = own ? m1_we    : m0_we;
    assign own_adr = own ? m1_adr   : m0_adr;
    assign own_dat = own ? m1_dat_m : m0_dat_m;

    assign full    = (state == OWN) && (cnt == CNT_MAX);
    assign accept  = s_cyc && s_stb && !s_stall;
    // An ACK with nothing outstanding is not counted, so cnt never wraps
    assign ack_cnt = s_ack && (cnt != '0);

    wb_arb_sel u_sel (
        .req    ({m1_cyc, m0_cyc}),
        .ptr    (rr_ptr),
        .winner (winner)
    );

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Tie pointer moves to the other master on every new grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (state == IDLE && any_req)
            rr_ptr <= ~winner;
    end
`else
    assign rr_ptr = 1'b0;
`endif

    // State, owner and outstanding counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            own   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant/release decisions and outstanding-strobe bookkeeping
    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        cnt_nxt   = cnt;
        if (accept && !ack_cnt)
            cnt_nxt = cnt + CW'(1);
        else if (ack_cnt && !accept)
            cnt_nxt = cnt - CW'(1);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWN;
                    own_nxt   = winner;
                end
            end
            OWN: begin
                // Dropping CYC aborts whatever is still in flight
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux and master responses; non-owners see a stalled bus
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_m  = '0;
        gnt      = 2'b00;
        m0_ack   = 1'b0;
        m0_stall = 1'b1;
        m0_dat_s = '0;
        m1_ack   = 1'b0;
        m1_stall = 1'b1;
        m1_dat_s = '0;
        if (state == OWN) begin
            s_cyc   = own_cyc;
            s_stb   = own_stb && !full;
            s_we    = own_we;
            s_adr   = own_adr;
            s_dat_m = own_dat;
            if (own) begin
                gnt      = 2'b10;
                m1_ack   = s_ack;
                m1_stall = s_stall || full;
                m1_dat_s = s_dat_s;
            end else begin
                gnt      = 2'b01;
                m0_ack   = s_ack;
                m0_stall = s_stall || full;
                m0_dat_s = s_dat_s;
            end
        end
    end

endmodule
